forward_selection_addr_pipe: RTL and testbench

FORWARD_SELECTION_ADDR_PIPE -- requirements
Module: forward_selection_addr_pipe

---
 rtl/forward_selection_addr_pipe.sv | 180 ++++++++++++++++++
 tb/tb_forward_selection_addr_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_selection_addr_pipe.sv
// forward_selection_addr_pipe
// Address cross-bar between two local ports (x0, x1) and an up/low
// forwarding cascade. The routing comes from an 8-bit configuration word
// that is held in a shadow register and committed only when the datapath is
// quiet. If the datapath does not go quiet, the commit is forced after
// CFG_TIMEOUT waiting cycles.
//
// Configuration word bits:
//   [1:0] x0 source    [3:2] x1 source    [4] fwd_low from up
//   [5]   fwd_up from low   [6] x0 uses addr2   [7] x1 uses addr2
//
// Ports
//   clk_i, rst_n_i          clock, async active-low reset
//   cfg_forward_addr_i      new config word, captured by cfg_load_i
//   cfg_active_o            config word currently steering the mux
//   cfg_busy_o              a captured word is waiting to be committed
//   cfg_forced_o            one-cycle pulse when a commit was forced by timeout
//   x*_addr*_local_i/x*_req_i   local addresses and request valids
//   forward_*_i             cascade addresses and valids
//   x*_addr_o, forward_*_o  routed addresses/valids, LAT cycles after input
//
// Config sequencer states
//   state    | meaning
//   ST_IDLE  | no pending word, active config is final
//   ST_PEND  | shadow word waiting for idle datapath or timeout
module forward_selection_addr_pipe #(
   parameter int          ADDR_W      = 16,
   parameter int          LAT         = 1,
   parameter logic [7:0]  CFG_RST     = 8'h00,
   parameter int          CFG_TIMEOUT = 15
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [7:0]        cfg_forward_addr_i,
   input  logic              cfg_load_i,
   output logic [7:0]        cfg_active_o,
   output logic              cfg_busy_o,
   output logic              cfg_forced_o,
   input  logic [ADDR_W-1:0] x0_addr1_local_i,
   input  logic [ADDR_W-1:0] x0_addr2_local_i,
   input  logic [ADDR_W-1:0] x1_addr1_local_i,
   input  logic [ADDR_W-1:0] x1_addr2_local_i,
   input  logic              x0_req_i,
   input  logic              x1_req_i,
   input  logic [ADDR_W-1:0] forward_addr_up_i,
   input  logic [ADDR_W-1:0] forward_addr_low_i,
   input  logic              forward_vld_up_i,
   input  logic              forward_vld_low_i,
   output logic [ADDR_W-1:0] x0_addr_o,
   output logic [ADDR_W-1:0] x1_addr_o,
   output logic [ADDR_W-1:0] forward_addr_up_o,
   output logic [ADDR_W-1:0] forward_addr_low_o,
   output logic              x0_vld_o,
   output logic              x1_vld_o,
   output logic              forward_vld_up_o,
   output logic              forward_vld_low_o
);

   typedef enum logic {ST_IDLE, ST_PEND} cfg_state_t;

   cfg_state_t        state;
   logic [7:0]        cfg_a;
   logic [7:0]        cfg_s;
   logic [7:0]        wait_cnt;
   logic              forced;

   // lane index: 0 = x0, 1 = x1, 2 = forward up, 3 = forward low
   logic [ADDR_W-1:0] x0_loc;
   logic [ADDR_W-1:0] x1_loc;
   logic [ADDR_W-1:0] nxt_addr [4];
   logic [3:0]        nxt_vld;
   logic [ADDR_W-1:0] pipe_addr [LAT][4];
   logic [3:0]        pipe_vld  [LAT];
   logic              pipe_any;
   logic              idle;

   always_comb begin
      x0_loc = cfg_a[6] ? x0_addr2_local_i : x0_addr1_local_i;
      x1_loc = cfg_a[7] ? x1_addr2_local_i : x1_addr1_local_i;
      for (int i = 0; i < 4; i++) nxt_addr[i] = '0;
      nxt_vld = '0;

      case (cfg_a[1:0])
         2'b00:   begin nxt_addr[0] = x0_loc;             nxt_vld[0] = x0_req_i;          end
         2'b01:   begin nxt_addr[0] = x1_loc;             nxt_vld[0] = x1_req_i;          end
         2'b10:   begin nxt_addr[0] = forward_addr_low_i; nxt_vld[0] = forward_vld_low_i; end
         default: begin nxt_addr[0] = forward_addr_up_i;  nxt_vld[0] = forward_vld_up_i;  end
      endcase

      case (cfg_a[3:2])
         2'b00:   begin nxt_addr[1] = x1_loc;             nxt_vld[1] = x1_req_i;          end
         2'b01:   begin nxt_addr[1] = x0_loc;             nxt_vld[1] = x0_req_i;          end
         2'b10:   begin nxt_addr[1] = forward_addr_low_i; nxt_vld[1] = forward_vld_low_i; end
         default: begin nxt_addr[1] = forward_addr_up_i;  nxt_vld[1] = forward_vld_up_i;  end
      endcase

      if (cfg_a[5]) begin
         nxt_addr[2] = forward_addr_low_i;
         nxt_vld[2]  = forward_vld_low_i;
      end else begin
         nxt_addr[2] = x0_loc;
         nxt_vld[2]  = x0_req_i;
      end

      if (cfg_a[4]) begin
         nxt_addr[3] = forward_addr_up_i;
         nxt_vld[3]  = forward_vld_up_i;
      end else begin
         nxt_addr[3] = x0_loc;
         nxt_vld[3]  = x0_req_i;
      end
   end

   // Routing is resolved before stage 0, so beats already in flight keep
   // the config they entered with.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int s = 0; s < LAT; s++) begin
            for (int i = 0; i < 4; i++) pipe_addr[s][i] <= '0;
            pipe_vld[s] <= '0;
         end
      end else begin
         pipe_addr[0] <= nxt_addr;
         pipe_vld[0]  <= nxt_vld;
         for (int s = 1; s < LAT; s++) begin
            pipe_addr[s] <= pipe_addr[s-1];
            pipe_vld[s]  <= pipe_vld[s-1];
         end
      end
   end

   always_comb begin
      pipe_any = 1'b0;
      for (int s = 0; s < LAT; s++) pipe_any = pipe_any | (|pipe_vld[s]);
      idle = !(x0_req_i || x1_req_i || forward_vld_up_i || forward_vld_low_i) && !pipe_any;
   end

   // wait_cnt counts down from CFG_TIMEOUT; reaching zero while still
   // pending forces the commit, so it can never wrap.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= ST_IDLE;
         cfg_a    <= CFG_RST;
         cfg_s    <= '0;
         wait_cnt <= '0;
         forced   <= 1'b0;
      end else begin
         forced <= 1'b0;
         if (cfg_load_i) begin
            cfg_s    <= cfg_forward_addr_i;
            wait_cnt <= 8'(CFG_TIMEOUT);
            state    <= ST_PEND;
         end else if (state == ST_PEND) begin
            if (wait_cnt == 8'd0) begin
               cfg_a  <= cfg_s;
               state  <= ST_IDLE;
               forced <= 1'b1;
            end else if (idle) begin
               cfg_a <= cfg_s;
               state <= ST_IDLE;
            end else begin
               wait_cnt <= wait_cnt - 8'd1;
            end
         end
      end
   end

   assign cfg_active_o       = cfg_a;
   assign cfg_busy_o         = (state == ST_PEND);
   assign cfg_forced_o       = forced;
   assign x0_addr_o          = pipe_addr[LAT-1][0];
   assign x1_addr_o          = pipe_addr[LAT-1][1];
   assign forward_addr_up_o  = pipe_addr[LAT-1][2];
   assign forward_addr_low_o = pipe_addr[LAT-1][3];
   assign x0_vld_o           = pipe_vld[LAT-1][0];
   assign x1_vld_o           = pipe_vld[LAT-1][1];
   assign forward_vld_up_o   = pipe_vld[LAT-1][2];
   assign forward_vld_low_o  = pipe_vld[LAT-1][3];

endmodule

// File: tb/tb_forward_selection_addr_pipe.sv
module tb_forward_selection_addr_pipe;

   localparam int         LAT     = 2;
   localparam int         TO      = 15;
   localparam int         TO_T    = 3;
   localparam logic [7:0] CFG_RST = 8'h00;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  cfg_in = '0;
   logic        cfg_load = 1'b0;
   logic [15:0] x0a1 = '0, x0a2 = '0, x1a1 = '0, x1a2 = '0, fup_i = '0, flow_i = '0;
   logic        x0_req = 1'b0, x1_req = 1'b0, vup_i = 1'b0, vlow_i = 1'b0;

   logic [7:0]  cfg_active, t_active;
   logic        cfg_busy, cfg_forced, t_busy, t_forced;
   logic [15:0] x0_addr, x1_addr, fup_o, flow_o, t_x0_addr, t_x1_addr, t_fup_o, t_flow_o;
   logic        x0_vld, x1_vld, fvup_o, fvlow_o, t_x0_vld, t_x1_vld, t_fvup_o, t_fvlow_o;

   forward_selection_addr_pipe #(.ADDR_W(16), .LAT(LAT), .CFG_RST(CFG_RST), .CFG_TIMEOUT(TO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .cfg_forward_addr_i(cfg_in), .cfg_load_i(cfg_load),
      .cfg_active_o(cfg_active), .cfg_busy_o(cfg_busy), .cfg_forced_o(cfg_forced),
      .x0_addr1_local_i(x0a1), .x0_addr2_local_i(x0a2),
      .x1_addr1_local_i(x1a1), .x1_addr2_local_i(x1a2),
      .x0_req_i(x0_req), .x1_req_i(x1_req),
      .forward_addr_up_i(fup_i), .forward_addr_low_i(flow_i),
      .forward_vld_up_i(vup_i), .forward_vld_low_i(vlow_i),
      .x0_addr_o(x0_addr), .x1_addr_o(x1_addr),
      .forward_addr_up_o(fup_o), .forward_addr_low_o(flow_o),
      .x0_vld_o(x0_vld), .x1_vld_o(x1_vld),
      .forward_vld_up_o(fvup_o), .forward_vld_low_o(fvlow_o));

   forward_selection_addr_pipe #(.ADDR_W(16), .LAT(LAT), .CFG_RST(CFG_RST), .CFG_TIMEOUT(TO_T)) dut_to (
      .clk_i(clk), .rst_n_i(rst_n),
      .cfg_forward_addr_i(cfg_in), .cfg_load_i(cfg_load),
      .cfg_active_o(t_active), .cfg_busy_o(t_busy), .cfg_forced_o(t_forced),
      .x0_addr1_local_i(x0a1), .x0_addr2_local_i(x0a2),
      .x1_addr1_local_i(x1a1), .x1_addr2_local_i(x1a2),
      .x0_req_i(x0_req), .x1_req_i(x1_req),
      .forward_addr_up_i(fup_i), .forward_addr_low_i(flow_i),
      .forward_vld_up_i(vup_i), .forward_vld_low_i(vlow_i),
      .x0_addr_o(t_x0_addr), .x1_addr_o(t_x1_addr),
      .forward_addr_up_o(t_fup_o), .forward_addr_low_o(t_flow_o),
      .x0_vld_o(t_x0_vld), .x1_vld_o(t_x1_vld),
      .forward_vld_up_o(t_fvup_o), .forward_vld_low_o(t_fvlow_o));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a queue of routed beats, LAT deep, plus the
   // pending-config bookkeeping kept as plain integers.
   typedef struct packed {
      logic [15:0] a0, a1, aup, alow;
      logic        v0, v1, vup, vlow;
   } beat_t;

   beat_t      q[$];
   logic [7:0] m_a, m_s;
   bit         m_pend;
   int         m_waited;
   bit         m_forced;

   function automatic beat_t route(input logic [7:0] a);
      logic [15:0] src[4];
      logic        sv[4];
      int          x1_src[4];
      int          k;
      beat_t       b;
      src[0] = a[6] ? x0a2 : x0a1;  sv[0] = x0_req;
      src[1] = a[7] ? x1a2 : x1a1;  sv[1] = x1_req;
      src[2] = flow_i;              sv[2] = vlow_i;
      src[3] = fup_i;               sv[3] = vup_i;
      x1_src = '{1, 0, 2, 3};
      k = int'(a[1:0]);        b.a0 = src[k];   b.v0 = sv[k];
      k = x1_src[a[3:2]];      b.a1 = src[k];   b.v1 = sv[k];
      k = a[5] ? 2 : 0;        b.aup = src[k];  b.vup = sv[k];
      k = a[4] ? 3 : 0;        b.alow = src[k]; b.vlow = sv[k];
      return b;
   endfunction

   task automatic model_reset();
      m_a = CFG_RST; m_s = '0; m_pend = 0; m_waited = 0; m_forced = 0;
      q.delete();
   endtask

   task automatic model_step();
      beat_t b;
      bit    in_flight;
      bit    quiet;
      if (!rst_n) begin
         model_reset();
         return;
      end
      b = route(m_a);
      in_flight = 0;
      foreach (q[i]) if (q[i].v0 || q[i].v1 || q[i].vup || q[i].vlow) in_flight = 1;
      quiet = !(x0_req || x1_req || vup_i || vlow_i) && !in_flight;
      m_forced = 0;
      if (cfg_load) begin
         m_s = cfg_in; m_pend = 1; m_waited = 0;
      end else if (m_pend) begin
         if (m_waited >= TO) begin
            m_a = m_s; m_pend = 0; m_forced = 1;
         end else if (quiet) begin
            m_a = m_s; m_pend = 0;
         end else begin
            m_waited = m_waited + 1;
         end
      end
      q.push_back(b);
      if (q.size() > LAT) void'(q.pop_front());
   endtask

   task automatic check_model();
      beat_t e;
      e = (q.size() == LAT) ? q[0] : '0;
      chk("m_x0_addr", x0_addr, e.a0);     chk("m_x0_vld", x0_vld, e.v0);
      chk("m_x1_addr", x1_addr, e.a1);     chk("m_x1_vld", x1_vld, e.v1);
      chk("m_fup_addr", fup_o, e.aup);     chk("m_fup_vld", fvup_o, e.vup);
      chk("m_flow_addr", flow_o, e.alow);  chk("m_flow_vld", fvlow_o, e.vlow);
      chk("m_active", cfg_active, m_a);
      chk("m_busy", cfg_busy, m_pend);
      chk("m_forced", cfg_forced, m_forced);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_model();
   endtask

   task automatic clear_inputs();
      cfg_load = 0; x0_req = 0; x1_req = 0; vup_i = 0; vlow_i = 0;
   endtask

   task automatic drain();
      clear_inputs();
      repeat (LAT + 2) cyc();
   endtask

   task automatic load_idle(input logic [7:0] v);
      cfg_in = v; cfg_load = 1;
      cyc();
      cfg_load = 0;
      cyc();
   endtask

   typedef struct {
      logic [7:0]  cfg;
      logic [15:0] e0, e1, eup, elow;
   } vec_t;

   vec_t tbl[6];

   initial begin
      tbl[0] = '{8'h00, 16'h1111, 16'h3333, 16'h1111, 16'h1111};
      tbl[1] = '{8'h0E, 16'h6666, 16'h5555, 16'h1111, 16'h1111};
      tbl[2] = '{8'h35, 16'h3333, 16'h1111, 16'h6666, 16'h5555};
      tbl[3] = '{8'hC3, 16'h5555, 16'h4444, 16'h2222, 16'h2222};
      tbl[4] = '{8'h4A, 16'h6666, 16'h6666, 16'h2222, 16'h2222};
      tbl[5] = '{8'h8D, 16'h4444, 16'h5555, 16'h1111, 16'h1111};

      model_reset();
      repeat (2) cyc();
      rst_n = 1;
      chk("rst_active", cfg_active, CFG_RST);
      chk("rst_busy", cfg_busy, 0);
      chk("rst_vlds", {x0_vld, x1_vld, fvup_o, fvlow_o}, 4'b0000);

      // straight-through after reset
      x0a1 = 16'h1234; x0_req = 1;
      cyc();
      x0_req = 0;
      repeat (LAT - 1) cyc();
      chk("st_x0_addr", x0_addr, 16'h1234);
      chk("st_x0_vld", x0_vld, 1);
      chk("st_fup_addr", fup_o, 16'h1234);
      chk("st_flow_addr", flow_o, 16'h1234);
      chk("st_fvlds", {fvup_o, fvlow_o}, 2'b11);
      chk("st_x1_vld", x1_vld, 0);
      drain();

      // routing table, one config per row
      x0a1 = 16'h1111; x0a2 = 16'h2222; x1a1 = 16'h3333; x1a2 = 16'h4444;
      fup_i = 16'h5555; flow_i = 16'h6666;
      foreach (tbl[r]) begin
         load_idle(tbl[r].cfg);
         chk("tbl_active", cfg_active, tbl[r].cfg);
         chk("tbl_t_active", t_active, tbl[r].cfg);
         x0_req = 1; x1_req = 1; vup_i = 1; vlow_i = 1;
         cyc();
         clear_inputs();
         repeat (LAT - 1) cyc();
         chk("tbl_x0", x0_addr, tbl[r].e0);
         chk("tbl_x1", x1_addr, tbl[r].e1);
         chk("tbl_fup", fup_o, tbl[r].eup);
         chk("tbl_flow", flow_o, tbl[r].elow);
         chk("tbl_vlds", {x0_vld, x1_vld, fvup_o, fvlow_o}, 4'b1111);
         drain();
      end

      // idle commit of 0E
      load_idle(8'h00);
      drain();
      cfg_in = 8'h0E; cfg_load = 1;
      cyc();
      cfg_load = 0;
      chk("ic_busy_pend", cfg_busy, 1);
      chk("ic_active_old", cfg_active, 8'h00);
      cyc();
      chk("ic_busy_done", cfg_busy, 0);
      chk("ic_active_new", cfg_active, 8'h0E);
      fup_i = 16'hABCD; vup_i = 1;
      repeat (LAT) cyc();
      chk("ic_x1_tracks_up", x1_addr, 16'hABCD);
      chk("ic_x1_vld", x1_vld, 1);
      drain();

      // busy commit: traffic for 5 cycles, commit one cycle after drain
      cfg_in = 8'h01; cfg_load = 1; x0_req = 1;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (k == 1) cfg_load = 0;
         if (k == 5) x0_req = 0;
         chk("bc_active", cfg_active, (k >= 8) ? 8'h01 : 8'h0E);
         chk("bc_forced", cfg_forced, 0);
      end
      drain();

      // timeout on the CFG_TIMEOUT=3 instance, continuous traffic
      load_idle(8'h00);
      drain();
      chk("to_t_active_init", t_active, 8'h00);
      for (int k = 1; k <= 10; k++) begin
         x0a1 = 16'(k); fup_i = 16'hF000 + 16'(k); x0_req = 1; vup_i = 1;
         cfg_in = 8'h03; cfg_load = (k == 1);
         cyc();
         chk("to_active", t_active, (k >= 5) ? 8'h03 : 8'h00);
         chk("to_forced", t_forced, (k == 5));
         if (k >= 2) begin
            chk("to_x0_route", t_x0_addr, (k - 1 <= 5) ? 16'(k - 1) : 16'hF000 + 16'(k - 1));
            chk("to_x0_vld", t_x0_vld, 1);
         end
      end
      drain();
      repeat (TO) cyc();

      // back-to-back loads while idle
      cfg_in = 8'h10; cfg_load = 1;
      cyc();
      chk("bb_active_1", cfg_active, 8'h03);
      cfg_in = 8'h20;
      cyc();
      chk("bb_active_2", cfg_active, 8'h03);
      cfg_load = 0;
      cyc();
      chk("bb_active_3", cfg_active, 8'h20);
      cyc();
      chk("bb_active_4", cfg_active, 8'h20);
      drain();

      // reset while a commit is pending under traffic
      x0_req = 1; x1_req = 1; cfg_in = 8'hFF; cfg_load = 1;
      cyc();
      cfg_load = 0;
      repeat (2) cyc();
      #2 rst_n = 0;
      model_reset();
      #1;
      chk("mr_active", cfg_active, CFG_RST);
      chk("mr_busy", cfg_busy, 0);
      chk("mr_vlds", {x0_vld, x1_vld, fvup_o, fvlow_o}, 4'b0000);
      chk("mr_t_active", t_active, CFG_RST);
      chk("mr_t_vlds", {t_x0_vld, t_x1_vld, t_fvup_o, t_fvlow_o}, 4'b0000);
      clear_inputs();
      cyc();
      rst_n = 1;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("mr_after_active", cfg_active, CFG_RST);
         chk("mr_after_busy", cfg_busy, 0);
      end

      // randomized traffic and config loads
      for (int n = 0; n < 500; n++) begin
         x0a1 = 16'($urandom); x0a2 = 16'($urandom);
         x1a1 = 16'($urandom); x1a2 = 16'($urandom);
         fup_i = 16'($urandom); flow_i = 16'($urandom);
         x0_req = ($urandom_range(0, 2) == 0);
         x1_req = ($urandom_range(0, 2) == 0);
         vup_i  = ($urandom_range(0, 2) == 0);
         vlow_i = ($urandom_range(0, 2) == 0);
         cfg_in = 8'($urandom);
         cfg_load = ($urandom_range(0, 9) == 0);
         cyc();
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
